mem_stream_arbiter: RTL and testbench

Shares one memory-stream slave port (req/gnt/addr/wdata/strb/we, one-cycle rvalid/rdata response) between NUM_REQ memory-stream masters. Typical use: several AXI-to-memory bridges or a debug master accessing the system-manager register bank. Requests are granted in the same cycle through a combinational mux. An internal in-order ID FIFO routes each response back to the requester that issued it.

---
 rtl/mem_stream_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_stream_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_arbiter.sv
// Arbitrates NUM_REQ memory-stream masters onto one slave port, routing responses back via an in-order ID FIFO.
// Define MEM_STREAM_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest requesting index wins.
module mem_stream_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int ADDR_WIDTH      = 8,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NUM_REQ-1:0]               req_i,
   output logic [NUM_REQ-1:0]               gnt_o,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  strb_i,
   input  logic [NUM_REQ-1:0]               we_i,
   output logic [NUM_REQ-1:0]               rvalid_o,
   output logic [DATA_WIDTH-1:0]            rdata_o,
   output logic                             mem_req_o,
   input  logic                             mem_gnt_i,
   output logic [ADDR_WIDTH-1:0]            mem_addr_o,
   output logic [DATA_WIDTH-1:0]            mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0]          mem_strb_o,
   output logic                             mem_we_o,
   input  logic                             mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
   output logic                             err_o
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [IDX_W-1:0] sel;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;

   logic [IDX_W-1:0] id_mem_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] head;

`ifdef MEM_STREAM_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_q, rr_d;
   int               rr_idx;
   logic             found;

   // Scan upward from the rr pointer, wrapping, and take the first requester.
   always_comb begin
      sel    = '0;
      found  = 1'b0;
      rr_idx = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         rr_idx = int'(rr_q) + off;
         if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
         if (!found && req_i[rr_idx]) begin
            sel   = IDX_W'(rr_idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (push) rr_d = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= '0;
      else         rr_q <= rr_d;
   end
`else
   always_comb begin
      sel = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_i[k]) sel = IDX_W'(k);
      end
   end
`endif

   assign full        = (cnt_q == CNT_W'(MAX_OUTSTANDING));
   assign empty       = (cnt_q == '0);
   assign mem_req_o   = (|req_i) & ~full;
   assign push        = mem_req_o & mem_gnt_i;
   assign pop         = mem_rvalid_i & ~empty;
   assign head        = id_mem_q[rptr_q];

   assign mem_addr_o  = addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
   assign mem_wdata_o = wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
   assign mem_strb_o  = strb_i[sel*STRB_W +: STRB_W];
   assign mem_we_o    = we_i[sel];
   assign rdata_o     = mem_rdata_i;
   assign err_o       = err_q;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
         assign gnt_o[gi]    = push & (sel == IDX_W'(gi));
         assign rvalid_o[gi] = pop & (head == IDX_W'(gi));
      end
   endgenerate

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      err_d  = err_q | (mem_rvalid_i & empty);
      if (push) wptr_d = (wptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_d = (rptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   // ID storage needs no reset: entries are only read while counted as valid.
   always_ff @(posedge clk_i) begin
      if (push) id_mem_q[wptr_q] <= sel;
   end

endmodule

// File: tb/tb_mem_stream_arbiter.sv
// Directed bench for mem_stream_arbiter with default parameters (2 requesters, 2 outstanding).
// Expectations follow the selection policy chosen by MEM_STREAM_ARB_ROUND_ROBIN_EN.
module tb_mem_stream_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [1:0]  req_i;
   logic [1:0]  gnt_o;
   logic [15:0] addr_i;
   logic [63:0] wdata_i;
   logic [7:0]  strb_i;
   logic [1:0]  we_i;
   logic [1:0]  rvalid_o;
   logic [31:0] rdata_o;
   logic        mem_req_o;
   logic        mem_gnt_i;
   logic [7:0]  mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_strb_o;
   logic        mem_we_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        err_o;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [1:0] exp_g [4];

   mem_stream_arbiter dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (req_i),
      .gnt_o       (gnt_o),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .strb_i      (strb_i),
      .we_i        (we_i),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .mem_req_o   (mem_req_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_strb_o  (mem_strb_o),
      .mem_we_o    (mem_we_o),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
`ifdef MEM_STREAM_ARB_ROUND_ROBIN_EN
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
      rst_ni = 1'b0; req_i = '0; addr_i = '0; wdata_i = '0; strb_i = '0; we_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      #2;
      chk("reset_gnt", 32'(gnt_o), 32'h0);
      chk("reset_rvalid", 32'(rvalid_o), 32'h0);
      chk("reset_memreq", 32'(mem_req_o), 32'h0);
      chk("reset_err", 32'(err_o), 32'h0);
      step(); step();
      rst_ni = 1'b1;
      step();

      // Single write from requester 1
      req_i = 2'b10; addr_i[15:8] = 8'h00; wdata_i[63:32] = 32'h1A2B3C01; strb_i[7:4] = 4'hF;
      we_i = 2'b10; mem_gnt_i = 1'b1; addr_i[7:0] = 8'h55;
      #1;
      chk("single_gnt", 32'(gnt_o), 32'h2);
      chk("single_we", 32'(mem_we_o), 32'h1);
      chk("single_addr", 32'(mem_addr_o), 32'h00);
      chk("single_wdata", mem_wdata_o, 32'h1A2B3C01);
      chk("single_strb", 32'(mem_strb_o), 32'hF);
      step();
      req_i = 2'b00; we_i = 2'b00; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
      #1;
      chk("single_rvalid", 32'(rvalid_o), 32'h2);
      chk("single_rdata", rdata_o, 32'hDEADBEEF);
      step();
      mem_rvalid_i = 1'b0;

      // Contention: both requesters held for 4 cycles
      req_i = 2'b11; addr_i = 16'h2010; mem_rdata_i = 32'h0;
      for (int c = 0; c < 4; c++) begin
         mem_rvalid_i = (c != 0);
         #1;
         chk($sformatf("cont_gnt%0d", c), 32'(gnt_o), 32'(exp_g[c]));
         chk($sformatf("cont_rvalid%0d", c), 32'(rvalid_o), (c == 0) ? 32'h0 : 32'(exp_g[c-1]));
         step();
      end
      req_i = 2'b00; mem_rvalid_i = 1'b1;
      #1;
      chk("cont_rvalid4", 32'(rvalid_o), 32'(exp_g[3]));
      step();
      mem_rvalid_i = 1'b0;

      // Backpressure: no grant while mem_gnt_i is low
      req_i = 2'b01; mem_gnt_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp_gnt%0d", c), 32'(gnt_o), 32'h0);
         chk($sformatf("bp_memreq%0d", c), 32'(mem_req_o), 32'h1);
         step();
      end
      req_i = 2'b11;
      #1;
      chk("bp_rr_hold_addr", 32'(mem_addr_o), 32'h10);
      step();
      req_i = 2'b01; mem_gnt_i = 1'b1;
      #1;
      chk("bp_release_gnt", 32'(gnt_o), 32'h1);
      step();
      req_i = 2'b00; mem_rvalid_i = 1'b1;
      #1;
      chk("bp_rvalid", 32'(rvalid_o), 32'h1);
      step();
      mem_rvalid_i = 1'b0;

      // Full: two handshakes, then stall until a response pops one entry
      req_i = 2'b01;
      #1; chk("full_gnt_a", 32'(gnt_o), 32'h1); step();
      #1; chk("full_gnt_b", 32'(gnt_o), 32'h1); step();
      #1;
      chk("full_memreq", 32'(mem_req_o), 32'h0);
      chk("full_gnt", 32'(gnt_o), 32'h0);
      step();
      mem_rvalid_i = 1'b1;
      #1;
      chk("full_pop_rvalid", 32'(rvalid_o), 32'h1);
      chk("full_nobypass_gnt", 32'(gnt_o), 32'h0);
      step();
      mem_rvalid_i = 1'b0;
      #1; chk("full_resume_gnt", 32'(gnt_o), 32'h1); step();
      req_i = 2'b00; mem_rvalid_i = 1'b1;
      #1; chk("full_drain0", 32'(rvalid_o), 32'h1); step();
      #1; chk("full_drain1", 32'(rvalid_o), 32'h1); step();
      mem_rvalid_i = 1'b0;
      #1; chk("full_err_clear", 32'(err_o), 32'h0);

      // Spurious response with empty FIFO
      mem_rvalid_i = 1'b1;
      #1;
      chk("spur_rvalid", 32'(rvalid_o), 32'h0);
      chk("spur_err_same", 32'(err_o), 32'h0);
      step();
      mem_rvalid_i = 1'b0;
      #1; chk("spur_err_set", 32'(err_o), 32'h1);
      step(); step();
      chk("spur_err_sticky", 32'(err_o), 32'h1);

      // Reset with two outstanding requests, then a late response
      req_i = 2'b01;
      #1; chk("rst_gnt_a", 32'(gnt_o), 32'h1); step();
      #1; chk("rst_gnt_b", 32'(gnt_o), 32'h1); step();
      req_i = 2'b00;
      rst_ni = 1'b0;
      #1;
      chk("rst_err", 32'(err_o), 32'h0);
      chk("rst_memreq", 32'(mem_req_o), 32'h0);
      chk("rst_rvalid", 32'(rvalid_o), 32'h0);
      step();
      rst_ni = 1'b1;
      step();
      mem_rvalid_i = 1'b1;
      #1; chk("late_rvalid", 32'(rvalid_o), 32'h0);
      step();
      mem_rvalid_i = 1'b0;
      #1; chk("late_err", 32'(err_o), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
